register_file: RTL and testbench
================================

Name: register_file

Overview:
- Parametrised successor to the single CE-gated 8-bit register: a multi-entry register file for the 65C02 datapath (A, X, Y, SP by default).
- One write port applies an in-place operation: load, increment, decrement, shift or rotate.
- Two asynchronous read ports.
- Registered N/Z/C flag outputs and a result-valid strobe feed the status-register logic.

Parameters:
- WIDTH, 8, data width of each entry.
- NREGS, 4, number of entries (1..2^ADDR_W).
- ADDR_W, 2, address width of all address ports.
- RESET_VAL, 0, reset value of every entry except SP_INDEX.
- SP_INDEX, 3, entry that resets to SP_RESET (value ≥ NREGS disables the special case).
- SP_RESET, all ones (8'hFF), reset value of entry SP_INDEX.

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- CE  in  1  clock enable; CE=0 freezes all state
- OP  in  3  000 NOP, 001 LOAD, 010 INC, 011 DEC, 100 ASL, 101 LSR, 110 ROL, 111 ROR
- WADDR  in  ADDR_W  target entry of OP
- IN  in  WIDTH  load data
- CIN  in  1  carry into ROL/ROR
- RADDR_A  in  ADDR_W  read address A
- RADDR_B  in  ADDR_W  read address B
- OUT_A  out  WIDTH  contents of entry RADDR_A (combinational from storage)
- OUT_B  out  WIDTH  contents of entry RADDR_B
- N_FLAG  out  1  MSB of last executed result (registered)
- Z_FLAG  out  1  last executed result == 0 (registered)
- C_FLAG  out  1  carry out of last shift/rotate (registered)
- VALID  out  1  one-cycle pulse: flags/entry updated by an executed op
- ERR  out  1  one-cycle pulse: non-NOP op with WADDR ≥ NREGS

Behaviour:
- Reset:
  - All state changes occur on the CLK rising edge only.
  - RST=1 overrides CE and OP.
  - Entries ← RESET_VAL; entry SP_INDEX ← SP_RESET.
  - N_FLAG, Z_FLAG, C_FLAG, VALID, ERR ← 0.
- Execution:
  - Executed op = CE=1, RST=0, OP≠NOP, WADDR<NREGS.
  - Result written to entry WADDR at the edge.
  - N/Z updated from the result at the same edge; VALID=1 for exactly the following cycle.
- Operation results (R = current entry value):
  - LOAD: IN.
  - INC: R+1 mod 2^WIDTH.
  - DEC: R−1 mod 2^WIDTH.
  - ASL: R<<1, LSB=0, C=R[MSB].
  - LSR: R>>1, MSB=0, C=R[0].
  - ROL: {R[MSB−1:0],CIN}, C=R[MSB].
  - ROR: {CIN,R[MSB:1]}, C=R[0].
- C_FLAG is changed only by ASL/LSR/ROL/ROR. LOAD/INC/DEC leave it unchanged (65C02 semantics).
- Wrap-around is silent, with no overflow output:
  - INC of all-ones → 0, Z=1.
  - DEC of 0 → all-ones, N=1.
- CE=0 or OP=NOP: no entry or flag change; VALID=0, ERR=0 next cycle.
- WADDR ≥ NREGS with OP≠NOP and CE=1:
  - Storage and flags unchanged, VALID=0.
  - ERR=1 for one cycle.
- Read ports:
  - Pure combinational reads of storage; no write bypass.
  - A read of WADDR in the cycle of a write returns the old value; the new value is visible after the edge.
  - RADDR ≥ NREGS reads 0.
- Latency: one cycle from op presentation to updated entry, flags and VALID.
- Back-to-back ops to the same entry each use the value written by the previous edge (e.g. INC,INC = +2).
- Reset mid-stream: an op presented in the same cycle as RST=1 is discarded; VALID is not asserted for it.

Test Plan:
- Reset: RST=1 one cycle → OUT of entries 0..2 = 8'h00, entry 3 = 8'hFF; N/Z/C/VALID/ERR = 0.
- LOAD 8'h80 to entry 1, then INC entry 1:
  - After the LOAD: read 1 = 8'h80, N=1, Z=0, VALID pulse.
  - After the INC: read 1 = 8'h81, C unchanged.
- Wrap:
  - DEC entry 0 (=8'h00) → 8'hFF, N=1, Z=0.
  - INC entry 3 (=8'hFF) → 8'h00, Z=1, N=0.
- Shifts:
  - LOAD 8'h81, then ASL → 8'h02, C=1.
  - ROR with CIN=1 → 8'h81, C=0.
  - LSR → 8'h40, C=1, N=0.
- Gating:
  - CE=0 with OP=LOAD 8'h55 → entry unchanged, VALID=0.
  - Same op with CE=1 and RST=1 → reset values, op discarded.
  - Parametrised build NREGS=3: OP=INC with WADDR=3 → ERR pulse, no state change.
- Read-during-write: LOAD 8'h12 to entry 2 while RADDR_A=2 → OUT_A shows the old value that cycle and 8'h12 the next.

Source files
------------

// File: rtl/register_file.sv
// Multi-entry datapath register file: one op-applying write port, two async read ports,
// registered N/Z/C flags with VALID/ERR strobes for the status-register logic.
module register_file #(
  parameter int              WIDTH     = 8,
  parameter int              NREGS     = 4,
  parameter int              ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int              SP_INDEX  = 3,
  parameter logic [WIDTH-1:0] SP_RESET  = '1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic [2:0]        OP,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  IN,
  input  logic              CIN,
  input  logic [ADDR_W-1:0] RADDR_A,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [WIDTH-1:0]  OUT_A,
  output logic [WIDTH-1:0]  OUT_B,
  output logic              N_FLAG,
  output logic              Z_FLAG,
  output logic              C_FLAG,
  output logic              VALID,
  output logic              ERR
);

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_ASL  = 3'b100;
  localparam logic [2:0] OP_LSR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_ROR  = 3'b111;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic             n_q, z_q, c_q, valid_q, err_q;

  logic [WIDTH-1:0] cur, res_d;
  logic             hit, c_d, c_upd, exec_d, err_d;

  // Address decode by loop so out-of-range addresses never index storage.
  always_comb begin
    OUT_A = '0;
    OUT_B = '0;
    cur   = '0;
    hit   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (RADDR_A == ADDR_W'(i)) OUT_A = regs_q[i];
      if (RADDR_B == ADDR_W'(i)) OUT_B = regs_q[i];
      if (WADDR == ADDR_W'(i)) begin
        cur = regs_q[i];
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    res_d = cur;
    c_d   = c_q;
    c_upd = 1'b0;
    unique case (OP)
      OP_NOP:  res_d = cur;
      OP_LOAD: res_d = IN;
      OP_INC:  res_d = cur + WIDTH'(1);
      OP_DEC:  res_d = cur - WIDTH'(1);
      OP_ASL:  begin res_d = {cur[WIDTH-2:0], 1'b0}; c_d = cur[WIDTH-1]; c_upd = 1'b1; end
      OP_LSR:  begin res_d = {1'b0, cur[WIDTH-1:1]}; c_d = cur[0];       c_upd = 1'b1; end
      OP_ROL:  begin res_d = {cur[WIDTH-2:0], CIN};  c_d = cur[WIDTH-1]; c_upd = 1'b1; end
      OP_ROR:  begin res_d = {CIN, cur[WIDTH-1:1]};  c_d = cur[0];       c_upd = 1'b1; end
      default: res_d = cur;
    endcase
  end

  assign exec_d = CE && (OP != OP_NOP) && hit;
  assign err_d  = CE && (OP != OP_NOP) && !hit;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET : RESET_VAL;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= exec_d;
      err_q   <= err_d;
      if (exec_d) begin
        for (int i = 0; i < NREGS; i++)
          if (WADDR == ADDR_W'(i)) regs_q[i] <= res_d;
        n_q <= res_d[WIDTH-1];
        z_q <= (res_d == '0);
        if (c_upd) c_q <= c_d;
      end
    end
  end

  assign N_FLAG = n_q;
  assign Z_FLAG = z_q;
  assign C_FLAG = c_q;
  assign VALID  = valid_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_register_file.sv
// Directed vector bench for register_file: default 4-entry build plus a 3-entry build for ERR.
module tb_register_file;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, CE, CIN;
  logic [2:0] OP;
  logic [1:0] WADDR, RADDR_A, RADDR_B;
  logic [7:0] IN, OUT_A, OUT_B;
  logic       N_FLAG, Z_FLAG, C_FLAG, VALID, ERR;

  logic       d3_RST, d3_CE, d3_CIN;
  logic [2:0] d3_OP;
  logic [1:0] d3_WADDR, d3_RADDR_A, d3_RADDR_B;
  logic [7:0] d3_IN, d3_OUT_A, d3_OUT_B;
  logic       d3_N, d3_Z, d3_C, d3_VALID, d3_ERR;

  register_file dut (
    .CLK(CLK), .RST(RST), .CE(CE), .OP(OP), .WADDR(WADDR), .IN(IN), .CIN(CIN),
    .RADDR_A(RADDR_A), .RADDR_B(RADDR_B), .OUT_A(OUT_A), .OUT_B(OUT_B),
    .N_FLAG(N_FLAG), .Z_FLAG(Z_FLAG), .C_FLAG(C_FLAG), .VALID(VALID), .ERR(ERR)
  );

  register_file #(.NREGS(3)) dut3 (
    .CLK(CLK), .RST(d3_RST), .CE(d3_CE), .OP(d3_OP), .WADDR(d3_WADDR), .IN(d3_IN), .CIN(d3_CIN),
    .RADDR_A(d3_RADDR_A), .RADDR_B(d3_RADDR_B), .OUT_A(d3_OUT_A), .OUT_B(d3_OUT_B),
    .N_FLAG(d3_N), .Z_FLAG(d3_Z), .C_FLAG(d3_C), .VALID(d3_VALID), .ERR(d3_ERR)
  );

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3,
                         ASL = 3'd4, LSR = 3'd5, ROL = 3'd6, ROR = 3'd7;

  typedef struct {
    string      name;
    logic       rst, ce;
    logic [2:0] op;
    logic [1:0] waddr, raddr;
    logic [7:0] din;
    logic       cin;
    logic [7:0] e_out;
    logic       e_n, e_z, e_c, e_v, e_e;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rst, input logic ce,
                              input logic [2:0] op, input logic [1:0] waddr,
                              input logic [1:0] raddr, input logic [7:0] din, input logic cin,
                              input logic [7:0] e_out, input logic e_n, input logic e_z,
                              input logic e_c, input logic e_v, input logic e_e);
    vec_t v;
    v.name = name; v.rst = rst; v.ce = ce; v.op = op; v.waddr = waddr; v.raddr = raddr;
    v.din = din; v.cin = cin; v.e_out = e_out;
    v.e_n = e_n; v.e_z = e_z; v.e_c = e_c; v.e_v = e_v; v.e_e = e_e;
    return v;
  endfunction

  vec_t vecs[17];

  initial begin
    RST = 1'b1; CE = 1'b0; OP = NOP; WADDR = '0; IN = '0; CIN = 1'b0;
    RADDR_A = '0; RADDR_B = '0;
    d3_RST = 1'b1; d3_CE = 1'b0; d3_OP = NOP; d3_WADDR = '0; d3_IN = '0; d3_CIN = 1'b0;
    d3_RADDR_A = '0; d3_RADDR_B = '0;

    //                 name        rst ce  op    wa    ra    din    cin  out    n z c v e
    vecs[0]  = mk("reset_e0",    1, 0, NOP,  2'd0, 2'd0, 8'h00, 0, 8'h00, 0,0,0,0,0);
    vecs[1]  = mk("reset_e3",    0, 1, NOP,  2'd0, 2'd3, 8'h00, 0, 8'hFF, 0,0,0,0,0);
    vecs[2]  = mk("reset_e1",    0, 1, NOP,  2'd0, 2'd1, 8'h00, 0, 8'h00, 0,0,0,0,0);
    vecs[3]  = mk("reset_e2",    0, 1, NOP,  2'd0, 2'd2, 8'h00, 0, 8'h00, 0,0,0,0,0);
    vecs[4]  = mk("load80",      0, 1, LOAD, 2'd1, 2'd1, 8'h80, 0, 8'h80, 1,0,0,1,0);
    vecs[5]  = mk("inc81",       0, 1, INC,  2'd1, 2'd1, 8'h00, 0, 8'h81, 1,0,0,1,0);
    vecs[6]  = mk("dec_wrap",    0, 1, DEC,  2'd0, 2'd0, 8'h00, 0, 8'hFF, 1,0,0,1,0);
    vecs[7]  = mk("inc_wrap",    0, 1, INC,  2'd3, 2'd3, 8'h00, 0, 8'h00, 0,1,0,1,0);
    vecs[8]  = mk("load81",      0, 1, LOAD, 2'd2, 2'd2, 8'h81, 0, 8'h81, 1,0,0,1,0);
    vecs[9]  = mk("asl",         0, 1, ASL,  2'd2, 2'd2, 8'h00, 0, 8'h02, 0,0,1,1,0);
    vecs[10] = mk("ror_cin1",    0, 1, ROR,  2'd2, 2'd2, 8'h00, 1, 8'h81, 1,0,0,1,0);
    vecs[11] = mk("lsr",         0, 1, LSR,  2'd2, 2'd2, 8'h00, 0, 8'h40, 0,0,1,1,0);
    vecs[12] = mk("load_keep_c", 0, 1, LOAD, 2'd0, 2'd0, 8'h07, 0, 8'h07, 0,0,1,1,0);
    vecs[13] = mk("ce0_gate",    0, 0, LOAD, 2'd2, 2'd2, 8'h55, 0, 8'h40, 0,0,1,0,0);
    vecs[14] = mk("rol_cin0",    0, 1, ROL,  2'd2, 2'd2, 8'h00, 0, 8'h80, 1,0,0,1,0);
    vecs[15] = mk("inc_b2b_1",   0, 1, INC,  2'd0, 2'd0, 8'h00, 0, 8'h08, 0,0,0,1,0);
    vecs[16] = mk("inc_b2b_2",   0, 1, INC,  2'd0, 2'd0, 8'h00, 0, 8'h09, 0,0,0,1,0);

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      RST = vecs[i].rst; CE = vecs[i].ce; OP = vecs[i].op; WADDR = vecs[i].waddr;
      IN = vecs[i].din; CIN = vecs[i].cin; RADDR_A = vecs[i].raddr; RADDR_B = vecs[i].raddr;
      @(posedge CLK); #1;
      chk({vecs[i].name, ".outA"}, 32'(OUT_A), 32'(vecs[i].e_out));
      chk({vecs[i].name, ".outB"}, 32'(OUT_B), 32'(vecs[i].e_out));
      chk({vecs[i].name, ".nzcve"}, {27'd0, N_FLAG, Z_FLAG, C_FLAG, VALID, ERR},
          {27'd0, vecs[i].e_n, vecs[i].e_z, vecs[i].e_c, vecs[i].e_v, vecs[i].e_e});
    end

    // Reset with a live op in the same cycle: op discarded, no VALID.
    @(negedge CLK);
    RST = 1'b1; CE = 1'b1; OP = LOAD; WADDR = 2'd2; IN = 8'h55; RADDR_A = 2'd2; RADDR_B = 2'd3;
    @(posedge CLK); #1;
    chk("rst_op.e2", 32'(OUT_A), 32'h00);
    chk("rst_op.e3", 32'(OUT_B), 32'hFF);
    chk("rst_op.flags", {27'd0, N_FLAG, Z_FLAG, C_FLAG, VALID, ERR}, 32'd0);

    // Read-during-write: old value before the edge, new value after.
    @(negedge CLK);
    RST = 1'b0; CE = 1'b1; OP = LOAD; WADDR = 2'd2; IN = 8'h12; RADDR_A = 2'd2;
    #1;
    chk("rdw.before", 32'(OUT_A), 32'h00);
    @(posedge CLK); #1;
    chk("rdw.after", 32'(OUT_A), 32'h12);
    @(negedge CLK);
    OP = NOP;
    @(posedge CLK); #1;
    chk("nop.valid_drop", 32'(VALID), 32'd0);

    // 3-entry build: out-of-range write raises ERR and changes nothing.
    @(negedge CLK);
    d3_RST = 1'b0; d3_CE = 1'b1; d3_OP = LOAD; d3_WADDR = 2'd2; d3_IN = 8'h5A;
    d3_RADDR_A = 2'd2; d3_RADDR_B = 2'd3;
    @(posedge CLK); #1;
    chk("n3.load", 32'(d3_OUT_A), 32'h5A);
    chk("n3.rd_oob", 32'(d3_OUT_B), 32'h00);
    @(negedge CLK);
    d3_OP = INC; d3_WADDR = 2'd3;
    @(posedge CLK); #1;
    chk("n3.err", {29'd0, d3_ERR, d3_VALID, d3_N}, {29'd0, 1'b1, 1'b0, 1'b0});
    chk("n3.e2_kept", 32'(d3_OUT_A), 32'h5A);
    chk("n3.rd_oob2", 32'(d3_OUT_B), 32'h00);
    @(negedge CLK);
    d3_OP = NOP; d3_RADDR_A = 2'd0;
    @(posedge CLK); #1;
    chk("n3.err_pulse", 32'(d3_ERR), 32'd0);
    chk("n3.e0", 32'(d3_OUT_A), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
